// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-addressed little-endian data memory with a valid/ready request port,
// sized loads/stores with sign/zero extension, alignment errors and fixed read latency.
module data_memory_pipe #(
  parameter int DMEM_DATA_WIDTH = 32,
  parameter int DMEM_ADDR_WIDTH = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       wr_en,
  input  logic [1:0]                 rw_mode,
  input  logic                       rd_unsigned,
  input  logic [DMEM_ADDR_WIDTH-1:0] addr,
  input  logic [DMEM_DATA_WIDTH-1:0] w_data,
  output logic                       resp_valid,
  output logic [DMEM_DATA_WIDTH-1:0] r_data,
  output logic                       resp_err
);
  localparam int BYTES = DMEM_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DMEM_ADDR_WIDTH;
  localparam int OFFW = $clog2(BYTES);
  localparam int LW = DMEM_ADDR_WIDTH - OFFW;
  localparam int L = READ_LATENCY;

  typedef enum logic {INIT, READY} state_t;

  state_t                     state;
  logic [LW-1:0]              line;
  logic [7:0]                 mem [DEPTH];
  logic                       acc;
  logic                       err;
  logic                       sign;
  logic [3:0]                 nbytes;
  logic [DMEM_DATA_WIDTH-1:0] ld;
  logic [DMEM_DATA_WIDTH-1:0] d_in;
  logic [L-1:0]               pv;
  logic [L-1:0]               pe;
  logic [DMEM_DATA_WIDTH-1:0] pd [L];

  assign acc = req_valid & req_ready;

  always_comb nbytes = rw_mode == 2'b00 ? 4'd4 : rw_mode == 2'b01 ? 4'd2 : rw_mode == 2'b10 ? 4'd1 : 4'd8;

  always_comb err = rw_mode == 2'b01 ? addr[0] :
                    rw_mode == 2'b00 ? |addr[1:0] :
                    rw_mode == 2'b11 ? (DMEM_DATA_WIDTH == 32) || (|addr[2:0]) : 1'b0;

  // Little-endian assembly; bytes above the access size are then filled from the top accessed bit.
  always_comb begin
    ld = '0;
    sign = 1'b0;
    for (int i = 0; i < BYTES; i++)
      if (i < int'(nbytes)) begin
        ld[8*i +: 8] = mem[addr + DMEM_ADDR_WIDTH'(i)];
        sign = ld[8*i+7];
      end
    for (int i = 0; i < BYTES; i++)
      if (i >= int'(nbytes) && sign && !rd_unsigned) ld[8*i +: 8] = 8'hFF;
  end

  assign d_in = (err || wr_en) ? '0 : ld;

  // Array has no reset; INIT clears it line by line instead.
  always_ff @(posedge clk)
    if (state == INIT)
      for (int i = 0; i < BYTES; i++) mem[{line, OFFW'(i)}] <= 8'h00;
    else if (acc && wr_en && !err)
      for (int i = 0; i < BYTES; i++)
        if (i < int'(nbytes)) mem[addr + DMEM_ADDR_WIDTH'(i)] <= w_data[8*i +: 8];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      line <= '0;
      req_ready <= 1'b0;
    end else if (state == INIT) begin
      line <= line + LW'(1);
      if (&line) begin
        state <= READY;
        req_ready <= 1'b1;
      end
    end

  // Stage data only moves with a valid, so the last stage holds the previous response.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < L; i++) pd[i] <= '0;
    end else begin
      pv[0] <= acc;
      if (acc) begin
        pd[0] <= d_in;
        pe[0] <= err;
      end
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pe[i] <= pe[i-1];
        end
      end
    end

  assign resp_valid = pv[L-1];
  assign r_data = pd[L-1];
  assign resp_err = pe[L-1];
endmodule
